calendar_text_renderer: RTL
===========================

# calendar_text_renderer

Parametrised, pipelined text-overlay renderer for the calendar VGA path. It sits between the VGA timing generator and the RGB output pins. It draws a row of NUM_CHARS glyphs (date/time digits, separators, blanks) at a configurable origin, fetching glyph rows from the shared character ROM. It adds three things the plain renderer lacks: frame-synchronous text latching (no tearing), a blinking highlight over an edit-field range, and a delayed video_on so downstream sync stays aligned with rgb.

## Interface
Parameters:
- COORD_W, 12, width of pixel_x/pixel_y
- CHAR_W, 32, glyph width in pixels; power of two, ≤ 32
- CHAR_H, 32, glyph height in pixels; power of two, ≤ 32
- NUM_CHARS, 19, characters per text row, 1..32
- ORIGIN_X, 0, left edge of text box in pixels
- ORIGIN_Y, 0, top edge of text box in pixels
- BLINK_FRAMES, 30, frames per blink half-period, ≥ 1
- FG_COLOR, 3'b111, normal glyph colour
- BG_COLOR, 3'b000, background and blank colour
- HL_COLOR, 3'b110, highlighted glyph colour

Ports:
- clk_148_5MHz  in  1  pixel clock
- reset  in  1  asynchronous, active-low reset
- pixel_x  in  COORD_W  current horizontal pixel
- pixel_y  in  COORD_W  current vertical pixel
- video_on  in  1  active-video qualifier for pixel_x/pixel_y
- frame_tick  in  1  one-cycle pulse, once per frame
- char_codes  in  4*NUM_CHARS  text; char i at [4i+3:4i], i=0 leftmost; 4'hA ":", 4'hB ".", 4'hF blank
- edit_en  in  1  enable highlight
- edit_lo  in  5  first highlighted char index
- edit_hi  in  5  last highlighted char index (inclusive)
- rom_char_code  out  4  glyph code to char ROM (registered)
- rom_row  out  5  glyph row to char ROM (registered; upper bits 0 when CHAR_H<32)
- rom_pixel_row  in  32  ROM row data, combinational response; bit CHAR_W-1 is leftmost pixel
- rgb  out  3  pixel colour
- video_on_out  out  1  video_on delayed to align with rgb
- blink_phase  out  1  current blink phase (1 = highlighted glyphs hidden)

## Operation
- Shadow text register: loaded from char_codes on every cycle with frame_tick=1. Reset value is all 4'hF. Rendering uses only the shadow.
- Blink counter: range 0..BLINK_FRAMES-1, advances on frame_tick. On a frame_tick at BLINK_FRAMES-1 it wraps to 0 and blink_phase toggles. Reset: counter 0, blink_phase 0.
- Stage 1, registered from inputs:
  - in_box = video_on and ORIGIN_X ≤ pixel_x < ORIGIN_X+NUM_CHARS*CHAR_W and ORIGIN_Y ≤ pixel_y < ORIGIN_Y+CHAR_H. Compares are unsigned, so coordinates left of or above the origin are outside.
  - idx = (pixel_x-ORIGIN_X)>>log2(CHAR_W).
  - xoff = low log2(CHAR_W) bits of the offset.
  - rom_row = (pixel_y-ORIGIN_Y) truncated.
  - rom_char_code = shadow[idx] when in_box, else 4'hF.
  - hl = edit_en and edit_lo ≤ idx ≤ edit_hi. If edit_lo > edit_hi there is never a highlight.
- Stage 2, registered: on = in_box and code≠4'hF and rom_pixel_row[CHAR_W-1-xoff]; hl, video_on carried.
- Stage 3, registered:
  - rgb = BG_COLOR when !video_on.
  - rgb = BG_COLOR when on=0.
  - When on=1 and hl=0: FG_COLOR.
  - When on=1 and hl=1: HL_COLOR if blink_phase=0, BG_COLOR if blink_phase=1.
- video_on_out is video_on delayed three cycles.

## Timing
- Latency is exactly 3 clocks from pixel_x/pixel_y/video_on to rgb/video_on_out. Throughput is one pixel per clock, with no stalls.
- rom_char_code/rom_row change 1 clock after the input pixel. rom_pixel_row is sampled at the following edge.
- Text change: pixels presented in the cycle after frame_tick and later use the new text. Pixels presented in the frame_tick cycle use the old text.
- blink_phase changes at the edge ending the wrapping frame_tick cycle. hl is sampled live with no frame alignment.
- frame_tick with video_on=1 is legal and handled identically.
- Reset asserted, including mid-frame, immediately forces:
  - rgb=BG_COLOR, video_on_out=0, blink_phase=0;
  - rom_char_code=4'hF, rom_row=0;
  - all pipeline valids 0 and shadow blank.
  Output resumes correctly 3 clocks after release.

## Test plan
- Reset then frame_tick with char_codes all 4'h8 and a ROM model returning 32'h8000_0000 -> at pixel_x=0, pixel_y=0, video_on=1, rgb=3'b111 exactly 3 clocks later. At pixel_x=1, rgb=3'b000.
- Change char_codes without frame_tick -> rgb unchanged. After frame_tick, the new glyph appears on pixels presented from the next cycle onward.
- Boundaries with ORIGIN_X=64, ORIGIN_Y=100:
  - pixel_x=63 -> rom_char_code=4'hF, rgb=BG;
  - pixel_x=64+19*32=672 -> rgb=BG;
  - pixel_y=132 -> rgb=BG;
  - pixel_x=671 -> rom_char_code=char 18.
- Highlight with edit_en=1, edit_lo=17, edit_hi=18, BLINK_FRAMES=2: glyph pixels in chars 17–18 alternate HL_COLOR/BG_COLOR every 2 frame_ticks, and char 16 stays FG_COLOR. With edit_lo=5, edit_hi=3, nothing is highlighted.
- video_on=0 during an in-box coordinate -> rgb=BG and video_on_out=0, 3 clocks delayed. A video_on pulse train is reproduced exactly 3 clocks later.
- Reset asserted mid-line with pipeline full -> rgb=000, video_on_out=0, blink_phase=0 with no clock edge. After release with no frame_tick, the text box renders blank.

Source files
------------

// File: rtl/calendar_text_renderer.sv
// calendar_text_renderer: 3-stage pipelined text overlay with frame-latched text and blinking edit highlight
module calendar_text_renderer #(
  parameter int COORD_W = 12,
  parameter int CHAR_W = 32,
  parameter int CHAR_H = 32,
  parameter int NUM_CHARS = 19,
  parameter int ORIGIN_X = 0,
  parameter int ORIGIN_Y = 0,
  parameter int BLINK_FRAMES = 30,
  parameter logic [2:0] FG_COLOR = 3'b111,
  parameter logic [2:0] BG_COLOR = 3'b000,
  parameter logic [2:0] HL_COLOR = 3'b110
) (
  input  logic                   clk_148_5MHz,
  input  logic                   reset,
  input  logic [COORD_W-1:0]     pixel_x,
  input  logic [COORD_W-1:0]     pixel_y,
  input  logic                   video_on,
  input  logic                   frame_tick,
  input  logic [4*NUM_CHARS-1:0] char_codes,
  input  logic                   edit_en,
  input  logic [4:0]             edit_lo,
  input  logic [4:0]             edit_hi,
  output logic [3:0]             rom_char_code,
  output logic [4:0]             rom_row,
  input  logic [31:0]            rom_pixel_row,
  output logic [2:0]             rgb,
  output logic                   video_on_out,
  output logic                   blink_phase
);
  localparam int XW = $clog2(CHAR_W);
  localparam int BW = BLINK_FRAMES > 1 ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [31:0] X0 = 32'(ORIGIN_X);
  localparam logic [31:0] X1 = 32'(ORIGIN_X + NUM_CHARS * CHAR_W);
  localparam logic [31:0] Y0 = 32'(ORIGIN_Y);
  localparam logic [31:0] Y1 = 32'(ORIGIN_Y + CHAR_H);
  logic [4*NUM_CHARS-1:0] shadow;
  logic [BW-1:0] blink_cnt;
  logic [31:0] px, py, off_x, idx;
  logic [4:0] xoff, row;
  logic [3:0] code;
  logic in_box, hl;
  logic s1_box, s1_hl, s1_vid;
  logic [4:0] s1_xoff;
  logic s2_on, s2_hl, s2_vid;
  always_comb begin
    px = 32'(pixel_x);
    py = 32'(pixel_y);
    off_x = px - X0;
    idx = off_x >> XW;
    xoff = off_x[4:0] & 5'(CHAR_W - 1);
    row = 5'(py - Y0) & 5'(CHAR_H - 1);
    in_box = video_on && px >= X0 && px < X1 && py >= Y0 && py < Y1;
    code = in_box ? shadow[{idx[4:0], 2'b00} +: 4] : 4'hF;
    hl = edit_en && 32'(edit_lo) <= idx && idx <= 32'(edit_hi);
  end
  // shadow is only updated on frame_tick so a frame never mixes old and new text
  always_ff @(posedge clk_148_5MHz or negedge reset)
    if (!reset) begin
      shadow <= {NUM_CHARS{4'hF}};
      blink_cnt <= '0;
      blink_phase <= 1'b0;
    end else if (frame_tick) begin
      shadow <= char_codes;
      blink_cnt <= blink_cnt == BW'(BLINK_FRAMES - 1) ? '0 : blink_cnt + BW'(1);
      blink_phase <= blink_cnt == BW'(BLINK_FRAMES - 1) ? ~blink_phase : blink_phase;
    end
  always_ff @(posedge clk_148_5MHz or negedge reset)
    if (!reset) begin
      rom_char_code <= 4'hF;
      rom_row <= '0;
      s1_box <= 1'b0;
      s1_hl <= 1'b0;
      s1_vid <= 1'b0;
      s1_xoff <= '0;
      s2_on <= 1'b0;
      s2_hl <= 1'b0;
      s2_vid <= 1'b0;
      rgb <= BG_COLOR;
      video_on_out <= 1'b0;
    end else begin
      rom_char_code <= code;
      rom_row <= row;
      s1_box <= in_box;
      s1_hl <= hl;
      s1_vid <= video_on;
      s1_xoff <= xoff;
      s2_on <= s1_box && rom_char_code != 4'hF && rom_pixel_row[5'(CHAR_W - 1) - s1_xoff];
      s2_hl <= s1_hl;
      s2_vid <= s1_vid;
      rgb <= (!s2_vid || !s2_on) ? BG_COLOR : !s2_hl ? FG_COLOR : blink_phase ? BG_COLOR : HL_COLOR;
      video_on_out <= s2_vid;
    end
endmodule
